// File: rtl/multi_dataflow_roberts_mdc_engine.sv
// multi_dataflow_roberts_mdc_engine
//
// Engine-side responder for the Roberts MDC accelerator. It takes the control
// struct from the HWPE control FSM and returns the flags struct. It bridges the
// in_pel / in_size source streams and the out_pel sink stream to the MDC
// dataflow kernel. It also counts delivered output pixels to generate done.
//
// Optional feature macro: ROBERTS_MDC_OUT_SKID_EN
//   defined   -> 2-entry registered skid buffer on the out_pel path.
//                Adds 1 cycle of latency and keeps 1 beat/cycle throughput.
//   undefined -> combinational pass-through from kernel output to out_pel.
//
// Ports
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   ctrl_i                          clear / enable / start / cnt_limit_out_pel
//   flags_o                         cnt_out_pel / done / ready
//   in_pel_*_i/o, in_size_*_i/o     source streams from the streamer
//   out_pel_*_o/i                   sink stream to the streamer
//   k_in_pel_*, k_in_size_*         kernel input ports (send/rdy/data)
//   k_out_pel_*                     kernel output port (send/rdy/data)
//   k_start_o                       one-cycle kernel start pulse (first RUN cycle)
//   state_dbg_o                     current FSM state, for observation only
//
// Handshake rule for every stream and kernel port: a beat transfers on a
// rising clock edge where valid (send) and ready (rdy) are both high. A
// producer that raises valid keeps it, and its data, stable until the beat
// transfers. This engine never makes its valid depend on the consumer's ready,
// except through the combinational pass-through, which only forwards the
// kernel's own send.
//
// The struct field widths come from the package constant CNT_LEN. The module
// parameter CNT_LEN must therefore match the package value.

package multi_dataflow_roberts_mdc_package;
    localparam int CNT_LEN = 1024;
    localparam int CW      = $clog2(CNT_LEN) + 1;

    typedef struct packed {
        logic          clear;
        logic          enable;
        logic          start;
        logic [CW-1:0] cnt_limit_out_pel;
    } ctrl_engine_multi_dataflow_roberts_mdc_t;

    typedef struct packed {
        logic [CW-1:0] cnt_out_pel;
        logic          done;
        logic          ready;
    } flags_engine_multi_dataflow_roberts_mdc_t;
endpackage

module multi_dataflow_roberts_mdc_engine
    import multi_dataflow_roberts_mdc_package::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_LEN    = multi_dataflow_roberts_mdc_package::CNT_LEN
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  ctrl_engine_multi_dataflow_roberts_mdc_t  ctrl_i,
    output flags_engine_multi_dataflow_roberts_mdc_t flags_o,

    input  logic                  in_pel_valid_i,
    output logic                  in_pel_ready_o,
    input  logic [DATA_WIDTH-1:0] in_pel_data_i,
    input  logic                  in_size_valid_i,
    output logic                  in_size_ready_o,
    input  logic [DATA_WIDTH-1:0] in_size_data_i,
    output logic                  out_pel_valid_o,
    input  logic                  out_pel_ready_i,
    output logic [DATA_WIDTH-1:0] out_pel_data_o,

    output logic                  k_in_pel_send_o,
    input  logic                  k_in_pel_rdy_i,
    output logic [DATA_WIDTH-1:0] k_in_pel_data_o,
    output logic                  k_in_size_send_o,
    input  logic                  k_in_size_rdy_i,
    output logic [DATA_WIDTH-1:0] k_in_size_data_o,
    input  logic                  k_out_pel_send_i,
    output logic                  k_out_pel_rdy_o,
    input  logic [DATA_WIDTH-1:0] k_out_pel_data_i,

    output logic                  k_start_o,
    output logic [1:0]            state_dbg_o
);

    localparam int LCW = $clog2(CNT_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [LCW-1:0] cnt_q;
    logic [LCW-1:0] limit_q;
    logic [LCW-1:0] cnt_inc;
    logic           k_start_q;
    logic           start_ok;
    logic           active;
    logic           out_hs;

    // A start is honoured only in IDLE, with enable high and no clear.
    assign start_ok = (state_q == IDLE) && ctrl_i.start && ctrl_i.enable && !ctrl_i.clear;
    assign active   = (state_q == RUN) && ctrl_i.enable;
    assign out_hs   = out_pel_valid_o && out_pel_ready_i;
    assign cnt_inc  = cnt_q + {{(LCW-1){1'b0}}, 1'b1};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (ctrl_i.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_i.start && ctrl_i.enable) begin
                        // A zero-length job completes without touching the kernel.
                        state_d = (ctrl_i.cnt_limit_out_pel == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // out_hs is already gated by enable, so a stall holds the state.
                    if (out_hs && (cnt_inc == limit_q)) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        flags_o.ready       = (state_q == IDLE);
        flags_o.done        = (state_q == DONE);
        flags_o.cnt_out_pel = cnt_q;
        k_start_o           = k_start_q;
        state_dbg_o         = state_q;

        k_in_pel_send_o  = active && in_pel_valid_i;
        in_pel_ready_o   = active && k_in_pel_rdy_i;
        k_in_pel_data_o  = active ? in_pel_data_i : '0;
        k_in_size_send_o = active && in_size_valid_i;
        in_size_ready_o  = active && k_in_size_rdy_i;
        k_in_size_data_o = active ? in_size_data_i : '0;
    end

    // ---------------- counter, latched limit, start pulse ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            limit_q   <= '0;
            k_start_q <= 1'b0;
        end else begin
            // The pulse lands in the first RUN cycle; zero-limit jobs get none.
            k_start_q <= start_ok && (ctrl_i.cnt_limit_out_pel != '0);
            if (ctrl_i.clear) begin
                cnt_q <= '0;
            end else if (start_ok) begin
                cnt_q   <= '0;
                limit_q <= ctrl_i.cnt_limit_out_pel;
            end else if ((state_q == RUN) && out_hs) begin
                cnt_q <= cnt_inc;
            end
        end
    end

`ifdef ROBERTS_MDC_OUT_SKID_EN
    // ---------------- 2-entry skid buffer on out_pel ----------------
    logic [DATA_WIDTH-1:0] skid_mem [2];
    logic                  skid_wr_q;
    logic                  skid_rd_q;
    logic [1:0]            skid_cnt_q;
    logic                  skid_push;
    logic                  skid_pop;

    // The kernel sees only buffer occupancy, never the sink's ready.
    assign k_out_pel_rdy_o = active && (skid_cnt_q != 2'd2);
    assign out_pel_valid_o = active && (skid_cnt_q != 2'd0);
    assign out_pel_data_o  = out_pel_valid_o ? skid_mem[skid_rd_q] : '0;
    assign skid_push       = k_out_pel_send_i && k_out_pel_rdy_o;
    assign skid_pop        = out_hs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            skid_wr_q   <= 1'b0;
            skid_rd_q   <= 1'b0;
            skid_cnt_q  <= 2'd0;
        end else if (ctrl_i.clear) begin
            skid_wr_q  <= 1'b0;
            skid_rd_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
        end else begin
            if (skid_push) begin
                skid_mem[skid_wr_q] <= k_out_pel_data_i;
                skid_wr_q           <= ~skid_wr_q;
            end
            if (skid_pop) begin
                skid_rd_q <= ~skid_rd_q;
            end
            case ({skid_push, skid_pop})
                2'b10:   skid_cnt_q <= skid_cnt_q + 2'd1;
                2'b01:   skid_cnt_q <= skid_cnt_q - 2'd1;
                default: skid_cnt_q <= skid_cnt_q;
            endcase
        end
    end
`else
    // ---------------- combinational pass-through ----------------
    assign out_pel_valid_o = active && k_out_pel_send_i;
    assign k_out_pel_rdy_o = active && out_pel_ready_i;
    assign out_pel_data_o  = active ? k_out_pel_data_i : '0;
`endif

endmodule

// File: tb/tb_multi_dataflow_roberts_mdc_engine.sv
// Testbench for multi_dataflow_roberts_mdc_engine (default pass-through build).
// A job-level reference model predicts every output on every cycle. An
// expected-data queue checks the order of beats on out_pel.
module tb_multi_dataflow_roberts_mdc_engine;
    import multi_dataflow_roberts_mdc_package::*;

    localparam int DW = 32;
    localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

    logic clk, rst_i;
    ctrl_engine_multi_dataflow_roberts_mdc_t  ctrl;
    flags_engine_multi_dataflow_roberts_mdc_t flags;
    logic          in_pel_valid_i, in_pel_ready_o, in_size_valid_i, in_size_ready_o;
    logic [DW-1:0] in_pel_data_i, in_size_data_i;
    logic          out_pel_valid_o, out_pel_ready_i;
    logic [DW-1:0] out_pel_data_o;
    logic          k_in_pel_send_o, k_in_pel_rdy_i, k_in_size_send_o, k_in_size_rdy_i;
    logic [DW-1:0] k_in_pel_data_o, k_in_size_data_o;
    logic          k_out_pel_send_i, k_out_pel_rdy_o;
    logic [DW-1:0] k_out_pel_data_i;
    logic          k_start_o;
    logic [1:0]    state_dbg_o;

    multi_dataflow_roberts_mdc_engine #(.DATA_WIDTH(DW), .CNT_LEN(1024)) dut (
        .clk_i(clk), .rst_i(rst_i), .ctrl_i(ctrl), .flags_o(flags),
        .in_pel_valid_i(in_pel_valid_i), .in_pel_ready_o(in_pel_ready_o), .in_pel_data_i(in_pel_data_i),
        .in_size_valid_i(in_size_valid_i), .in_size_ready_o(in_size_ready_o), .in_size_data_i(in_size_data_i),
        .out_pel_valid_o(out_pel_valid_o), .out_pel_ready_i(out_pel_ready_i), .out_pel_data_o(out_pel_data_o),
        .k_in_pel_send_o(k_in_pel_send_o), .k_in_pel_rdy_i(k_in_pel_rdy_i), .k_in_pel_data_o(k_in_pel_data_o),
        .k_in_size_send_o(k_in_size_send_o), .k_in_size_rdy_i(k_in_size_rdy_i), .k_in_size_data_o(k_in_size_data_o),
        .k_out_pel_send_i(k_out_pel_send_i), .k_out_pel_rdy_o(k_out_pel_rdy_o), .k_out_pel_data_i(k_out_pel_data_i),
        .k_start_o(k_start_o), .state_dbg_o(state_dbg_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic [DW-1:0] exp_q[$];

    // Job-level reference model
    int         m_phase;
    logic [10:0] m_cnt, m_limit;
    logic       m_kstart;
    logic       m_out_hs;

    // Kernel output source: beat i carries src_base + i
    int            src_idx, src_n;
    logic [DW-1:0] src_base;

    typedef struct {
        logic ipv, kipr, isv, kisr, kos, ordy, en;
        logic [5:0] exp_hs;
    } vec_t;
    vec_t tbl[8];

    task automatic model_reset();
        m_phase = P_IDLE; m_cnt = '0; m_limit = '0; m_kstart = 1'b0;
    endtask

    function automatic logic [115:0] model_outputs();
        logic act;
        act = (m_phase == P_RUN) && ctrl.enable;
        return {(m_phase == P_IDLE), (m_phase == P_DONE), m_cnt, m_kstart,
                act & in_pel_valid_i, act & k_in_pel_rdy_i, act ? in_pel_data_i : 32'd0,
                act & in_size_valid_i, act & k_in_size_rdy_i, act ? in_size_data_i : 32'd0,
                act & k_out_pel_send_i, act & out_pel_ready_i, act ? k_out_pel_data_i : 32'd0};
    endfunction

    function automatic logic [115:0] dut_outputs();
        return {flags.ready, flags.done, flags.cnt_out_pel, k_start_o,
                k_in_pel_send_o, in_pel_ready_o, k_in_pel_data_o,
                k_in_size_send_o, in_size_ready_o, k_in_size_data_o,
                out_pel_valid_o, k_out_pel_rdy_o, out_pel_data_o};
    endfunction

    // One job advances by the rules: a start in IDLE opens a job of m_limit beats,
    // each delivered beat counts, the last one leads to a one-cycle done.
    task automatic model_step();
        m_out_hs = (m_phase == P_RUN) && ctrl.enable && k_out_pel_send_i && out_pel_ready_i;
        if (ctrl.clear) begin
            model_reset();
        end else if (m_phase == P_IDLE) begin
            m_kstart = 1'b0;
            if (ctrl.start && ctrl.enable) begin
                m_cnt   = '0;
                m_limit = ctrl.cnt_limit_out_pel;
                if (m_limit == 0) m_phase = P_DONE;
                else begin m_phase = P_RUN; m_kstart = 1'b1; end
            end
        end else if (m_phase == P_RUN) begin
            m_kstart = 1'b0;
            if (m_out_hs) begin
                m_cnt = m_cnt + 11'd1;
                if (m_cnt == m_limit) m_phase = P_DONE;
            end
        end else begin
            m_kstart = 1'b0;
            m_phase  = P_IDLE;
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare all outputs at the falling edge, then step the model across the
    // rising edge and return at posedge+1 with inputs free to change.
    task automatic tick(input string name);
        logic [115:0] exp_v, act_v;
        @(negedge clk);
        exp_v = model_outputs();
        act_v = dut_outputs();
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
        end
        if (flags.done === 1'b1) done_seen++;
        model_step();
        if (m_out_hs && exp_q.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (out_pel_data_o !== e) begin
                errors++;
                $display("FAIL %s_order: got %h expected %h", name, out_pel_data_o, e);
            end
        end
        if (m_out_hs && src_idx < src_n) src_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cycle(input logic ordy);
        in_pel_valid_i   = 1'($urandom_range(0, 1));
        k_in_pel_rdy_i   = 1'($urandom_range(0, 1));
        in_pel_data_i    = $urandom;
        in_size_valid_i  = 1'($urandom_range(0, 1));
        k_in_size_rdy_i  = 1'($urandom_range(0, 1));
        in_size_data_i   = $urandom;
        out_pel_ready_i  = ordy;
        k_out_pel_send_i = (src_idx < src_n);
        k_out_pel_data_i = (src_idx < src_n) ? src_base + DW'(src_idx) : '0;
    endtask

    task automatic start_run(input int limit, input logic [DW-1:0] base);
        exp_q.delete();
        src_base = base; src_idx = 0; src_n = limit;
        for (int i = 0; i < limit; i++) exp_q.push_back(base + DW'(i));
        ctrl.start = 1'b1; ctrl.enable = 1'b1; ctrl.cnt_limit_out_pel = 11'(limit);
        done_seen = 0;
        drive_cycle(1'b1);
        tick("start");
        ctrl.start = 1'b0;
    endtask

    // mode 0: sink always ready, mode 1: sink ready on alternate cycles
    task automatic run_until_idle(input string name, input int mode);
        int cyc;
        for (cyc = 0; cyc < 300; cyc++) begin
            drive_cycle((mode == 0) ? 1'b1 : 1'(cyc % 2 == 0));
            tick(name);
            if (m_phase == P_IDLE) break;
        end
        if (cyc >= 300) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got no idle expected idle within 300 cycles", name);
        end
    endtask

    task automatic run_to_count(input string name, input int target);
        int cyc;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (m_cnt == 11'(target) || m_phase != P_RUN) break;
            drive_cycle(1'b1);
            tick(name);
        end
        if (cyc >= 300) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got count %0d expected %0d", name, m_cnt, target);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        ctrl = '0;
        in_pel_valid_i = 0; k_in_pel_rdy_i = 0; in_pel_data_i = '0;
        in_size_valid_i = 0; k_in_size_rdy_i = 0; in_size_data_i = '0;
        out_pel_ready_i = 0; k_out_pel_send_i = 0; k_out_pel_data_i = '0;
        src_idx = 0; src_n = 0; src_base = '0;
        model_reset();
        m_out_hs = 1'b0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        tick("reset_held");
        rst_i = 1'b0;
        tick("reset_released");

        // ---------------- basic run ----------------
        start_run(16, 32'h0000_0100);
        run_until_idle("basic", 0);
        check_int("basic_done_once", done_seen, 1);
        check_int("basic_all_beats", exp_q.size(), 0);
        tick("basic_idle");
        check_bit("basic_ready_back", flags.ready, 1'b1);

        // ---------------- backpressure ----------------
        start_run(8, 32'hA000_0000);
        run_until_idle("backpressure", 1);
        check_int("bp_done_once", done_seen, 1);
        check_int("bp_all_beats", exp_q.size(), 0);

        // ---------------- zero limit ----------------
        start_run(0, 32'h0);
        run_until_idle("zero_limit", 0);
        check_int("zero_done_once", done_seen, 1);
        check_int("zero_count", int'(flags.cnt_out_pel), 0);

        // ---------------- enable stall at count 3 ----------------
        start_run(10, 32'h0000_5000);
        run_to_count("stall_pre", 3);
        ctrl.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1);
            in_pel_valid_i = 1'b1; k_in_pel_rdy_i = 1'b1;
            tick("stall");
        end
        check_int("stall_count_held", int'(flags.cnt_out_pel), 3);
        ctrl.enable = 1'b1;
        run_until_idle("stall_resume", 0);
        check_int("stall_done_once", done_seen, 1);
        check_int("stall_all_beats", exp_q.size(), 0);

        // ---------------- clear at count 5 ----------------
        start_run(10, 32'h0000_6000);
        run_to_count("clear_pre", 5);
        ctrl.clear = 1'b1;
        drive_cycle(1'b1);
        tick("clear");
        ctrl.clear = 1'b0;
        exp_q.delete(); src_n = 0;
        drive_cycle(1'b1);
        tick("clear_after");
        check_bit("clear_ready", flags.ready, 1'b1);
        check_int("clear_count", int'(flags.cnt_out_pel), 0);
        start_run(4, 32'h0000_7000);
        run_until_idle("after_clear", 0);
        check_int("after_clear_beats", exp_q.size(), 0);

        // ---------------- asynchronous reset mid-run ----------------
        start_run(10, 32'h0000_8000);
        run_to_count("rst_pre", 4);
        drive_cycle(1'b1);
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_outputs() !== model_outputs()) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", dut_outputs(), model_outputs());
        end
        @(posedge clk);
        #1 rst_i = 1'b0;
        exp_q.delete(); src_n = 0;
        tick("after_reset");

        // ---------------- start while running ----------------
        start_run(6, 32'h0000_9000);
        run_to_count("restart_pre", 2);
        ctrl.start = 1'b1; ctrl.cnt_limit_out_pel = 11'd3;
        drive_cycle(1'b1);
        tick("restart_ignored");
        ctrl.start = 1'b0; ctrl.cnt_limit_out_pel = 11'd6;
        run_until_idle("restart", 0);
        check_int("restart_done_once", done_seen, 1);
        check_int("restart_all_beats", exp_q.size(), 0);

        // ---------------- table: RUN-state handshake gating ----------------
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'b111111};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'b100101};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'b011010};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'b101010};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'b010101};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000000};
        start_run(100, 32'h0);
        exp_q.delete(); src_n = 0;
        for (int i = 0; i < 8; i++) begin
            in_pel_valid_i = tbl[i].ipv; k_in_pel_rdy_i = tbl[i].kipr;
            in_size_valid_i = tbl[i].isv; k_in_size_rdy_i = tbl[i].kisr;
            k_out_pel_send_i = tbl[i].kos; out_pel_ready_i = tbl[i].ordy;
            ctrl.enable = tbl[i].en;
            in_pel_data_i = $urandom; in_size_data_i = $urandom; k_out_pel_data_i = $urandom;
            #1;
            checks++;
            if ({k_in_pel_send_o, in_pel_ready_o, k_in_size_send_o, in_size_ready_o,
                 out_pel_valid_o, k_out_pel_rdy_o} !== tbl[i].exp_hs) begin
                errors++;
                $display("FAIL table_%0d: got %b expected %b", i,
                         {k_in_pel_send_o, in_pel_ready_o, k_in_size_send_o, in_size_ready_o,
                          out_pel_valid_o, k_out_pel_rdy_o}, tbl[i].exp_hs);
            end
            tick("table");
        end
        check_int("table_count", int'(flags.cnt_out_pel), 1);
        ctrl.enable = 1'b1; ctrl.clear = 1'b1;
        tick("table_clear");
        ctrl.clear = 1'b0;

        // ---------------- randomized traffic ----------------
        src_n = 0;
        for (int i = 0; i < 1500; i++) begin
            drive_cycle(1'($urandom_range(0, 1)));
            k_out_pel_send_i = 1'($urandom_range(0, 1));
            k_out_pel_data_i = $urandom;
            ctrl.enable = ($urandom_range(0, 9) != 0);
            ctrl.start  = ($urandom_range(0, 5) == 0);
            ctrl.clear  = ($urandom_range(0, 60) == 0);
            if (m_phase == P_IDLE) ctrl.cnt_limit_out_pel = 11'($urandom_range(0, 12));
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
